// File: rtl/controlador_minado.sv
// Round-robin job scheduler that feeds one modulo_rendimiento miner and guards it with a watchdog.
// Optional CTRL_STATS_EN adds saturating per-outcome job counters (jobs_ok, jobs_timeout).
module controlador_minado #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*96-1:0]  req_bloque,
  input  logic [N_REQ*8-1:0]   req_target,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [23:0]          resp_hash,
  output logic                 resp_timeout,
  output logic                 busy,
`ifdef CTRL_STATS_EN
  output logic [15:0]          jobs_ok,
  output logic [15:0]          jobs_timeout,
`endif
  output logic                 inicio,
  output logic [95:0]          bloque_bytes,
  output logic [7:0]           target,
  output logic                 reset_datapath,
  input  logic                 terminado,
  input  logic [23:0]          hash
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLanzar,
    StEspera,
    StAborto,
    StRespuesta
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [95:0]      bloque_q, bloque_d;
  logic [7:0]       target_q, target_d;
  logic [23:0]      hash_q, hash_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             accept;
  logic             handshake;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned cand;
      cand = (32'(last_grant_q) + k) % N_REQ;
      if (!pick_found && req_valid[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign accept = (state_q == StIdle) && pick_found;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    bloque_d       = bloque_q;
    target_d       = target_q;
    hash_d         = hash_q;
    timeout_d      = timeout_q;
    cnt_d          = cnt_q;
    inicio         = 1'b0;
    reset_datapath = 1'b0;
    resp_valid     = '0;
    handshake      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          bloque_d = req_bloque[32'(pick_idx)*96 +: 96];
          target_d = req_target[32'(pick_idx)*8 +: 8];
          grant_d  = pick_idx;
          state_d  = StLanzar;
        end
      end
      StLanzar: begin
        inicio  = 1'b1;
        cnt_d   = '0;
        state_d = StEspera;
      end
      StEspera: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A completion on the last watchdog cycle still counts as success.
        if (terminado) begin
          hash_d    = hash;
          timeout_d = 1'b0;
          state_d   = StRespuesta;
        end else if (cnt_q == CNT_LAST) begin
          hash_d    = '0;
          timeout_d = 1'b1;
          state_d   = StAborto;
        end
      end
      StAborto: begin
        reset_datapath = 1'b1;
        state_d        = StRespuesta;
      end
      StRespuesta: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) begin
          handshake    = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= IDX_LAST;
      grant_q      <= '0;
      bloque_q     <= '0;
      target_q     <= '0;
      hash_q       <= '0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      bloque_q     <= bloque_d;
      target_q     <= target_d;
      hash_q       <= hash_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign bloque_bytes = bloque_q;
  assign target       = target_q;
  assign resp_hash    = hash_q;
  assign resp_timeout = timeout_q;

`ifdef CTRL_STATS_EN
  logic [15:0] jobs_ok_q, jobs_timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jobs_ok_q      <= '0;
      jobs_timeout_q <= '0;
    end else if (handshake) begin
      if (timeout_q) begin
        if (jobs_timeout_q != 16'hFFFF) begin
          jobs_timeout_q <= jobs_timeout_q + 16'd1;
        end
      end else if (jobs_ok_q != 16'hFFFF) begin
        jobs_ok_q <= jobs_ok_q + 16'd1;
      end
    end
  end

  assign jobs_ok      = jobs_ok_q;
  assign jobs_timeout = jobs_timeout_q;
`endif

endmodule

// File: tb/tb_controlador_minado.sv
// Directed bench for controlador_minado: round-robin, watchdog boundary, async reset, held responses.
// Expected responses go into a scoreboard queue at accept time and are popped when resp_valid rises.
module tb_controlador_minado;

  localparam int NR = 2;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [NR*96-1:0]  req_bloque;
  logic [NR*8-1:0]   req_target;
  logic [23:0]       resp_hash, hash;
  logic              resp_timeout, busy, inicio, reset_datapath, terminado;
  logic [95:0]       bloque_bytes;
  logic [7:0]        target;
`ifdef CTRL_STATS_EN
  logic [15:0]       jobs_ok, jobs_timeout;
`endif

  int checks   = 0;
  int failures = 0;
  int lastg;
  int exp_ok;
  int exp_to;

  typedef struct {
    int          idx;
    logic [23:0] h;
    logic        to;
  } resp_t;

  resp_t sb[$];

  always #5 clk = ~clk;

  controlador_minado #(
    .N_REQ          (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_bloque     (req_bloque),
    .req_target     (req_target),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hash      (resp_hash),
    .resp_timeout   (resp_timeout),
    .busy           (busy),
`ifdef CTRL_STATS_EN
    .jobs_ok        (jobs_ok),
    .jobs_timeout   (jobs_timeout),
`endif
    .inicio         (inicio),
    .bloque_bytes   (bloque_bytes),
    .target         (target),
    .reset_datapath (reset_datapath),
    .terminado      (terminado),
    .hash           (hash)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef CTRL_STATS_EN
    chk("jobs_ok", 96'(jobs_ok), 96'(exp_ok));
    chk("jobs_timeout", 96'(jobs_timeout), 96'(exp_to));
`endif
  endtask

  // lat = ESPERA cycle on which terminado is raised; 0 = miner never finishes.
  task automatic run_job(input logic [NR-1:0] mask, input int lat, input logic [23:0] h,
                         input logic [95:0] blk, input logic [7:0] tgt, input int hold);
    int    g;
    int    cyc;
    int    aborts;
    resp_t e;
    g = -1;
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (lastg + k) % NR;
      if (g < 0 && mask[i]) g = i;
    end
    for (int i = 0; i < NR; i++) begin
      req_bloque[i*96 +: 96] = (i == g) ? blk : ~blk;
      req_target[i*8 +: 8]   = (i == g) ? tgt : ~tgt;
    end
    req_valid = mask;
    #1;
    chk("req_ready_grant", 96'(req_ready), 96'(1) << g);
    step();
    chk("inicio_pulse", 96'(inicio), 96'(1));
    chk("bloque_latched", bloque_bytes, blk);
    chk("target_latched", 96'(target), 96'(tgt));
    chk("busy_lanzar", 96'(busy), 96'(1));
    chk("req_ready_busy", 96'(req_ready), 96'(0));
    e.idx = g;
    e.h   = (lat == 0) ? 24'h0 : h;
    e.to  = (lat == 0);
    sb.push_back(e);
    step();
    chk("inicio_one_cycle", 96'(inicio), 96'(0));
    aborts = 0;
    cyc    = 0;
    while (resp_valid == '0 && cyc < 40) begin
      cyc++;
      if (reset_datapath) aborts++;
      terminado = (cyc == lat);
      hash      = (cyc == lat) ? h : 24'hFFFFFF;
      step();
    end
    terminado = 1'b0;
    chk("cycles_to_resp", 96'(cyc), 96'((lat == 0) ? TO + 1 : lat));
    chk("abort_pulses", 96'(aborts), 96'((lat == 0) ? 1 : 0));
    e = sb.pop_front();
    chk("resp_valid", 96'(resp_valid), 96'(1) << e.idx);
    chk("resp_hash", 96'(resp_hash), 96'(e.h));
    chk("resp_timeout", 96'(resp_timeout), 96'(e.to));
    resp_ready = ~(NR'(1) << g);
    for (int n = 0; n < hold; n++) begin
      step();
      chk("hold_resp_valid", 96'(resp_valid), 96'(1) << e.idx);
      chk("hold_resp_hash", 96'(resp_hash), 96'(e.h));
      chk("hold_req_ready", 96'(req_ready), 96'(0));
      if (n == hold - 1) chk_stats();
    end
    resp_ready = NR'(1) << g;
    step();
    resp_ready = '0;
    req_valid  = '0;
    lastg      = g;
    if (e.to) exp_to++;
    else exp_ok++;
    chk("resp_done", 96'(resp_valid), 96'(0));
    chk("idle_after_job", 96'(busy), 96'(0));
    chk_stats();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    lastg  = NR - 1;
    exp_ok = 0;
    exp_to = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_bloque = '0;
    req_target = '0;
    resp_ready = '0;
    terminado  = 1'b0;
    hash       = '0;
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_inicio", 96'(inicio), 96'(0));
    chk("rst_reset_datapath", 96'(reset_datapath), 96'(0));
    chk("rst_resp_valid", 96'(resp_valid), 96'(0));
    chk("rst_resp_hash", 96'(resp_hash), 96'(0));
    chk("rst_resp_timeout", 96'(resp_timeout), 96'(0));
    chk("rst_bloque", bloque_bytes, 96'(0));
    chk("rst_target", 96'(target), 96'(0));
    chk("rst_req_ready", 96'(req_ready), 96'(0));
    do_reset();

    // Single requester; latency kept under the 16-cycle watchdog of this build.
    run_job(2'b01, 10, 24'h00ABCD, 96'h0123456789ABCDEF01234567, 8'h10, 0);

    // Both requesters held after reset: grants alternate 0,1,0,1.
    do_reset();
    run_job(2'b11, 1, 24'h111111, 96'hA5A5A5A5_00000000_11111111, 8'h01, 0);
    run_job(2'b11, 3, 24'h222222, 96'h5A5A5A5A_FFFFFFFF_22222222, 8'h02, 0);
    run_job(2'b11, 2, 24'h333333, 96'h01020304_05060708_090A0B0C, 8'h03, 0);
    run_job(2'b11, 5, 24'h444444, 96'hCAFEBABE_DEADBEEF_00C0FFEE, 8'h04, 0);

    // Watchdog abort, then the same requester succeeds.
    run_job(2'b10, 0, 24'h0, 96'hFEEDFACE_12345678_9ABCDEF0, 8'h20, 0);
    run_job(2'b10, 4, 24'h777777, 96'h0F0F0F0F_F0F0F0F0_33333333, 8'h21, 0);

    // Completion on the final watchdog cycle wins.
    run_job(2'b01, TO, 24'h000001, 96'h13579BDF_2468ACE0_55555555, 8'h30, 0);

    // Response held 10 cycles while requester 0 keeps requesting.
    run_job(2'b11, 6, 24'h0BEEF0, 96'h89ABCDEF_01234567_76543210, 8'h40, 10);

    // Async reset mid-ESPERA discards the job.
    req_bloque[0 +: 96] = 96'hDDDDDDDD_EEEEEEEE_FFFFFFFF;
    req_target[0 +: 8]  = 8'h55;
    req_valid           = 2'b01;
    step();
    req_valid = '0;
    step();
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 96'(busy), 96'(0));
    chk("async_rst_bloque", bloque_bytes, 96'(0));
    chk("async_rst_target", 96'(target), 96'(0));
    chk("async_rst_inicio", 96'(inicio), 96'(0));
    step();
    reset  = 1'b0;
    lastg  = NR - 1;
    exp_ok = 0;
    exp_to = 0;
    terminado = 1'b1;
    hash      = 24'h123456;
    step();
    terminado = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("late_terminado_no_resp", 96'(resp_valid), 96'(0));
      chk("late_terminado_idle", 96'(busy), 96'(0));
      step();
    end
    chk_stats();

    // After reset requester 0 wins first again.
    run_job(2'b11, 2, 24'h0F00D0, 96'h11112222_33334444_55556666, 8'h60, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
